// File: rtl/usb_reg_master_pkg.sv
// Shared constants for the CW USB register-bus initiator: FSM state
// encodings, default phase timings and a small sizing helper.
package usb_reg_master_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WDATA  = 3'd1;
  localparam logic [2:0] ST_SETUP  = 3'd2;
  localparam logic [2:0] ST_STROBE = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;
  localparam logic [2:0] ST_FINISH = 3'd5;

  localparam int DEF_SETUP_CYCLES  = 1;
  localparam int DEF_STROBE_CYCLES = 2;
  localparam int DEF_HOLD_CYCLES   = 1;

  // Largest of three phase lengths; sizes the shared phase timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/usb_reg_master_timer.sv
// Loadable down-counter with a zero flag. One instance times the
// SETUP, STROBE and HOLD phases in turn; a load of N-1 gives N cycles.
module usb_reg_master_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load on phase entry, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (reset)                 cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (cnt != '0)        cnt <= cnt - CNT_W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/usb_reg_master.sv
// Initiator for the CW USB register bus. Converts a valid/ready command
// into a chip-select-framed burst of timed read or write strobes. Every
// output is a flop; bus-level outputs are computed from the next state so
// they line up with the state they describe.
module usb_reg_master
  import usb_reg_master_pkg::*;
#(
  parameter int pADDR_WIDTH    = 8,
  parameter int pBYTECNT_SIZE  = 7,
  parameter int pSETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int pSTROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int pHOLD_CYCLES   = DEF_HOLD_CYCLES
) (
  input  logic                     usb_clk,
  input  logic                     reset_i,
  input  logic                     I_cmd_valid,
  output logic                     O_cmd_ready,
  input  logic                     I_cmd_write,
  input  logic [pADDR_WIDTH-1:0]   I_cmd_addr,
  input  logic [pBYTECNT_SIZE-1:0] I_cmd_len,
  input  logic [7:0]               I_wdata,
  input  logic                     I_wdata_valid,
  output logic                     O_wdata_ready,
  output logic [7:0]               O_rdata,
  output logic                     O_rdata_valid,
  output logic                     O_done,
  output logic                     O_cmd_err,
  output logic [pADDR_WIDTH-1:0]   O_cwusb_addr,
  output logic                     O_cwusb_cen,
  output logic                     O_cwusb_rdn,
  output logic                     O_cwusb_wrn,
  output logic [7:0]               O_cwusb_dout,
  output logic                     O_cwusb_dout_en,
  input  logic [7:0]               I_cwusb_din
);

  localparam int TMR_MAX = max3(pSETUP_CYCLES, pSTROBE_CYCLES, pHOLD_CYCLES);
  localparam int CNT_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(pSETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_STROBE = CNT_W'(pSTROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(pHOLD_CYCLES - 1);

  logic [2:0]               state, nstate;
  logic                     wr_q;
  logic [pBYTECNT_SIZE-1:0] byte_cnt;
  logic                     tmr_load;
  logic [CNT_W-1:0]         tmr_val;
  logic                     tmr_zero;
  logic                     accept;
  logic                     last_byte;

  assign accept    = (state == ST_IDLE) && I_cmd_valid && O_cmd_ready;
  assign last_byte = (byte_cnt == pBYTECNT_SIZE'(1));

  usb_reg_master_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (usb_clk),
    .reset    (reset_i),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Next-state and phase-timer load selection.
  always_comb begin
    nstate   = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (I_cmd_len == '0) begin
            nstate = ST_FINISH;
          end else if (I_cmd_write) begin
            nstate = ST_WDATA;
          end else begin
            nstate   = ST_SETUP;
            tmr_load = 1'b1;
            tmr_val  = LD_SETUP;
          end
        end
      end
      ST_WDATA: begin
        if (I_wdata_valid) begin
          nstate   = ST_SETUP;
          tmr_load = 1'b1;
          tmr_val  = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          nstate   = ST_STROBE;
          tmr_load = 1'b1;
          tmr_val  = LD_STROBE;
        end
      end
      ST_STROBE: begin
        if (tmr_zero) begin
          nstate   = ST_HOLD;
          tmr_load = 1'b1;
          tmr_val  = LD_HOLD;
        end
      end
      ST_HOLD: begin
        if (tmr_zero) begin
          if (last_byte) begin
            nstate = ST_FINISH;
          end else if (wr_q) begin
            nstate = ST_WDATA;
          end else begin
            nstate   = ST_SETUP;
            tmr_load = 1'b1;
            tmr_val  = LD_SETUP;
          end
        end
      end
      ST_FINISH: nstate = ST_IDLE;
      default:   nstate = ST_IDLE;
    endcase
  end

  // State, latched command, datapath and registered outputs.
  // O_wdata_ready is an acknowledge pulse in the cycle after the byte was
  // captured; the producer may present the next byte once it sees it,
  // since WDATA is not revisited for at least a full byte period.
  always_ff @(posedge usb_clk) begin
    if (reset_i) begin
      state           <= ST_IDLE;
      wr_q            <= 1'b0;
      byte_cnt        <= '0;
      O_cmd_ready     <= 1'b1;
      O_wdata_ready   <= 1'b0;
      O_rdata         <= 8'h00;
      O_rdata_valid   <= 1'b0;
      O_done          <= 1'b0;
      O_cmd_err       <= 1'b0;
      O_cwusb_addr    <= '0;
      O_cwusb_cen     <= 1'b1;
      O_cwusb_rdn     <= 1'b1;
      O_cwusb_wrn     <= 1'b1;
      O_cwusb_dout    <= 8'h00;
      O_cwusb_dout_en <= 1'b0;
    end else begin
      state         <= nstate;
      O_cmd_ready   <= (nstate == ST_IDLE);
      O_cwusb_cen   <= (nstate == ST_IDLE) || (nstate == ST_FINISH);
      // Strobe direction comes from the latched command; STROBE is never
      // entered straight from IDLE, so wr_q is always current here.
      O_cwusb_rdn   <= !((nstate == ST_STROBE) && !wr_q);
      O_cwusb_wrn   <= !((nstate == ST_STROBE) &&  wr_q);
      O_done        <= (nstate == ST_FINISH);
      O_cmd_err     <= (nstate == ST_FINISH) && (state == ST_IDLE);
      O_rdata_valid <= 1'b0;
      O_wdata_ready <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            wr_q         <= I_cmd_write;
            O_cwusb_addr <= I_cmd_addr;
            byte_cnt     <= I_cmd_len;
          end
        end
        ST_WDATA: begin
          if (I_wdata_valid) begin
            O_cwusb_dout    <= I_wdata;
            O_cwusb_dout_en <= 1'b1;
            O_wdata_ready   <= 1'b1;
          end
        end
        ST_STROBE: begin
          if (tmr_zero && !wr_q) begin
            O_rdata       <= I_cwusb_din;
            O_rdata_valid <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (tmr_zero) byte_cnt <= byte_cnt - pBYTECNT_SIZE'(1);
        end
        default: ;
      endcase

      if (nstate == ST_FINISH) O_cwusb_dout_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_usb_reg_master.sv
// Directed bench for usb_reg_master: default-timing instance with a
// behavioural responder and scoreboards, plus a slow-setup instance for
// back-to-back reads and busy-command rejection.
module tb_usb_reg_master;

  logic usb_clk = 1'b0;
  always #5 usb_clk = ~usb_clk;

  logic reset_i;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  always @(posedge usb_clk) cyc <= cyc + 1;

  // ---------------- instance 1: default timing ----------------
  logic       cmd_valid, cmd_write, wdata_valid;
  logic [7:0] cmd_addr, wdata;
  logic [6:0] cmd_len;
  logic       cmd_ready, wdata_ready, rdata_valid, done, cmd_err;
  logic [7:0] rdata, bus_addr, dout, din;
  logic       cen, rdn, wrn, dout_en;

  usb_reg_master dut (
    .usb_clk(usb_clk), .reset_i(reset_i),
    .I_cmd_valid(cmd_valid), .O_cmd_ready(cmd_ready), .I_cmd_write(cmd_write),
    .I_cmd_addr(cmd_addr), .I_cmd_len(cmd_len),
    .I_wdata(wdata), .I_wdata_valid(wdata_valid), .O_wdata_ready(wdata_ready),
    .O_rdata(rdata), .O_rdata_valid(rdata_valid), .O_done(done), .O_cmd_err(cmd_err),
    .O_cwusb_addr(bus_addr), .O_cwusb_cen(cen), .O_cwusb_rdn(rdn), .O_cwusb_wrn(wrn),
    .O_cwusb_dout(dout), .O_cwusb_dout_en(dout_en), .I_cwusb_din(din)
  );

  // ---------------- instance 2: setup 3, strobe 1, hold 2 ----------------
  logic       cmd_valid2, cmd_write2, wdata_valid2;
  logic [7:0] cmd_addr2, wdata2;
  logic [6:0] cmd_len2;
  logic       cmd_ready2, wdata_ready2, rdata_valid2, done2, cmd_err2;
  logic [7:0] rdata2, bus_addr2, dout2, din2;
  logic       cen2, rdn2, wrn2, dout_en2;

  usb_reg_master #(.pSETUP_CYCLES(3), .pSTROBE_CYCLES(1), .pHOLD_CYCLES(2)) dut2 (
    .usb_clk(usb_clk), .reset_i(reset_i),
    .I_cmd_valid(cmd_valid2), .O_cmd_ready(cmd_ready2), .I_cmd_write(cmd_write2),
    .I_cmd_addr(cmd_addr2), .I_cmd_len(cmd_len2),
    .I_wdata(wdata2), .I_wdata_valid(wdata_valid2), .O_wdata_ready(wdata_ready2),
    .O_rdata(rdata2), .O_rdata_valid(rdata_valid2), .O_done(done2), .O_cmd_err(cmd_err2),
    .O_cwusb_addr(bus_addr2), .O_cwusb_cen(cen2), .O_cwusb_rdn(rdn2), .O_cwusb_wrn(wrn2),
    .O_cwusb_dout(dout2), .O_cwusb_dout_en(dout_en2), .I_cwusb_din(din2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- responder model for instance 1 ----------------
  typedef struct { logic [7:0] a; int b; logic [7:0] d; } wr_t;
  wr_t        wq[$];
  logic [7:0] rq[$];
  int   bcnt = 0;
  logic prdn = 1'b1, pwrn = 1'b1, pcen = 1'b1;
  int   wrn_falls = 0, cen_falls = 0, cen_rises = 0;

  // Read data depends on the responder's byte counter, which advances on
  // strobe release and clears while chip-select is high.
  assign din = 8'hA5 + 8'(bcnt);

  always @(negedge usb_clk) begin
    if (pwrn && !wrn) wrn_falls++;
    if (pcen && !cen) cen_falls++;
    if (!pcen && cen) cen_rises++;
    if (cen) begin
      bcnt = 0;
    end else begin
      if (!pwrn && wrn) begin
        chk("wr_sb_nonempty", 32'(wq.size() > 0), 32'd1);
        if (wq.size() > 0) begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_addr", 32'(bus_addr), 32'(e.a));
          chk("wr_bytecnt", 32'(bcnt), 32'(e.b));
          chk("wr_data", 32'(dout), 32'(e.d));
        end
        bcnt++;
      end
      if (!prdn && rdn) bcnt++;
    end
    prdn = rdn; pwrn = wrn; pcen = cen;
  end

  // Read scoreboard and bus invariants for instance 1.
  always @(negedge usb_clk) begin
    if (rdata_valid) begin
      chk("rd_sb_nonempty", 32'(rq.size() > 0), 32'd1);
      if (rq.size() > 0) chk("rd_data", 32'(rdata), 32'(rq.pop_front()));
    end
    if (!rdn || !wrn) begin
      chk("inv_no_overlap", 32'(rdn | wrn), 32'd1);
      chk("inv_strobe_cen", 32'(cen), 32'd0);
    end
    if (!rdn) chk("inv_douten_read", 32'(dout_en), 32'd0);
  end

  // ---------------- instance 2 responder / monitors ----------------
  logic [7:0] rq2[$];
  int   t2[$];
  logic prdn2 = 1'b1;
  int   wrn2_falls = 0;
  logic pwrn2 = 1'b1;
  assign din2 = bus_addr2 ^ 8'h3C;

  always @(negedge usb_clk) begin
    if (prdn2 && !rdn2) t2.push_back(cyc);
    if (pwrn2 && !wrn2) wrn2_falls++;
    prdn2 = rdn2; pwrn2 = wrn2;
    if (rdata_valid2) begin
      chk("rd2_sb_nonempty", 32'(rq2.size() > 0), 32'd1);
      if (rq2.size() > 0) chk("rd2_data", 32'(rdata2), 32'(rq2.pop_front()));
    end
    if (!rdn2 || !wrn2) begin
      chk("inv2_no_overlap", 32'(rdn2 | wrn2), 32'd1);
      chk("inv2_strobe_cen", 32'(cen2), 32'd0);
    end
    if (!rdn2) chk("inv2_douten_read", 32'(dout_en2), 32'd0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic w, input logic [7:0] a, input logic [6:0] l);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge usb_clk);
      got = cmd_ready;
    end
    chk("cmd_ready_wait", 32'(got), 32'd1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    @(posedge usb_clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic issue2(input logic w, input logic [7:0] a, input logic [6:0] l);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge usb_clk);
      got = cmd_ready2;
    end
    chk("cmd_ready2_wait", 32'(got), 32'd1);
    cmd_valid2 = 1'b1; cmd_write2 = w; cmd_addr2 = a; cmd_len2 = l;
    @(posedge usb_clk);
    #1 cmd_valid2 = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge usb_clk);
      got = done;
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [5:0] v_cen, v_rdn, v_rv, v_done, v_rdy;
    logic [7:0] rd_at4;
    int base_w, base_cf, base_cr, nf, dc;
    logic pr, busy_ready, got;

    reset_i = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; wdata = 0; wdata_valid = 0;
    cmd_valid2 = 0; cmd_write2 = 0; cmd_addr2 = 0; cmd_len2 = 0; wdata2 = 0; wdata_valid2 = 0;
    repeat (3) @(posedge usb_clk);
    #1 reset_i = 1'b0;
    @(negedge usb_clk);

    // Reset values.
    chk("reset_ctl", 32'({cen, rdn, wrn, dout_en, rdata_valid, done, cmd_err, wdata_ready, cmd_ready}),
        32'(9'b111000001));
    chk("reset_data", 32'({bus_addr, dout, rdata}), 32'd0);

    // Read len 1 at 0x05: cycle-accurate trace over cycles 1..6.
    rq.push_back(8'hA5);
    issue(1'b0, 8'h05, 7'd1);
    rd_at4 = 8'h00;
    for (int k = 0; k < 6; k++) begin
      @(negedge usb_clk);
      v_cen[k] = cen; v_rdn[k] = rdn; v_rv[k] = rdata_valid; v_done[k] = done; v_rdy[k] = cmd_ready;
      if (k == 3) rd_at4 = rdata;
    end
    chk("rd1_cen_trace",  32'(v_cen),  32'(6'b110000));
    chk("rd1_rdn_trace",  32'(v_rdn),  32'(6'b111001));
    chk("rd1_rv_trace",   32'(v_rv),   32'(6'b001000));
    chk("rd1_done_trace", 32'(v_done), 32'(6'b010000));
    chk("rd1_rdy_trace",  32'(v_rdy),  32'(6'b100000));
    chk("rd1_rdata",      32'(rd_at4), 32'h0A5);

    // Write len 3 at 0x10 with gapped write data.
    base_w = wrn_falls; base_cf = cen_falls; base_cr = cen_rises;
    wq.push_back('{a: 8'h10, b: 0, d: 8'h11});
    wq.push_back('{a: 8'h10, b: 1, d: 8'h22});
    wq.push_back('{a: 8'h10, b: 2, d: 8'h33});
    issue(1'b1, 8'h10, 7'd3);
    for (int i = 0; i < 3; i++) begin
      repeat (4) @(negedge usb_clk);
      wdata = 8'h11 * 8'(i + 1);
      wdata_valid = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin
        @(negedge usb_clk);
        got = wdata_ready;
      end
      chk("wr_ready_seen", 32'(got), 32'd1);
      wdata_valid = 1'b0;
    end
    wait_done("wr_done");
    @(negedge usb_clk);
    chk("wr_strobe_count", 32'(wrn_falls - base_w), 32'd3);
    chk("wr_cen_falls", 32'(cen_falls - base_cf), 32'd1);
    chk("wr_cen_rises", 32'(cen_rises - base_cr), 32'd1);
    chk("wr_sb_drained", 32'(wq.size()), 32'd0);

    // Zero-length command: error completion, no bus activity.
    base_cf = cen_falls;
    issue(1'b0, 8'h44, 7'd0);
    @(negedge usb_clk);
    chk("len0_finish", 32'({done, cmd_err, cen, cmd_ready}), 32'(4'b1110));
    @(negedge usb_clk);
    chk("len0_ready_next", 32'({cmd_ready, done, cmd_err}), 32'(3'b100));
    chk("len0_no_cen", 32'(cen_falls - base_cf), 32'd0);

    // Reset during the second strobe of a 4-byte read.
    for (int i = 0; i < 4; i++) rq.push_back(8'hA5 + 8'(i));
    issue(1'b0, 8'h20, 7'd4);
    nf = 0; pr = 1'b1;
    for (int k = 0; k < 100 && nf < 2; k++) begin
      @(negedge usb_clk);
      if (pr && !rdn) nf++;
      pr = rdn;
    end
    chk("rst_second_strobe", 32'(nf), 32'd2);
    dc = 0;
    reset_i = 1'b1;
    @(posedge usb_clk);
    #1 reset_i = 1'b0;
    @(negedge usb_clk);
    chk("rst_bus_idle", 32'({cen, rdn, wrn, dout_en, cmd_ready, done}), 32'(6'b111010));
    chk("rst_addr", 32'(bus_addr), 32'd0);
    chk("rst_pending_bytes", 32'(rq.size()), 32'd3);
    rq.delete();
    for (int k = 0; k < 5; k++) begin
      @(negedge usb_clk);
      if (done) dc++;
    end
    chk("rst_no_done", 32'(dc), 32'd0);
    rq.push_back(8'hA5); rq.push_back(8'hA6);
    issue(1'b0, 8'h07, 7'd2);
    wait_done("post_rst_done");
    @(negedge usb_clk);
    chk("post_rst_sb", 32'(rq.size()), 32'd0);

    // Slow-setup instance: back-to-back reads, busy commands ignored.
    t2.delete();
    for (int i = 0; i < 3; i++) rq2.push_back(8'h30 ^ 8'h3C);
    issue2(1'b0, 8'h30, 7'd3);
    cmd_valid2 = 1'b1; cmd_write2 = 1'b1; cmd_addr2 = 8'h99; cmd_len2 = 7'd5;
    busy_ready = 1'b0; got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge usb_clk);
      if (cmd_ready2) busy_ready = 1'b1;
      got = done2;
    end
    cmd_valid2 = 1'b0;
    chk("b2_done1", 32'(got), 32'd1);
    chk("b2_busy_not_ready", 32'(busy_ready), 32'd0);
    chk("b2_rdn_count1", 32'(t2.size()), 32'd3);
    if (t2.size() == 3) begin
      chk("b2_period_a", 32'(t2[1] - t2[0]), 32'd6);
      chk("b2_period_b", 32'(t2[2] - t2[1]), 32'd6);
    end
    t2.delete();
    for (int i = 0; i < 2; i++) rq2.push_back(8'h31 ^ 8'h3C);
    issue2(1'b0, 8'h31, 7'd2);
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge usb_clk);
      got = done2;
    end
    chk("b2_done2", 32'(got), 32'd1);
    @(negedge usb_clk);
    chk("b2_rdn_count2", 32'(t2.size()), 32'd2);
    if (t2.size() == 2) chk("b2_period_c", 32'(t2[1] - t2[0]), 32'd6);
    chk("b2_no_write", 32'(wrn2_falls), 32'd0);
    chk("b2_sb_drained", 32'(rq2.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
